dcache_lookup_port: RTL

//  Requester-side client of the D$ tag-compare arbiter. Accepts one lookup (index+tag) from a

---
 rtl/dcache_lookup_port.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dcache_lookup_port.sv
// Requester-side lookup port for the D$ tag-compare arbiter: request, retry until granted, compare, respond.
// Optional hit/miss performance counters are enabled by defining DCACHE_LOOKUP_PERF_EN.
module dcache_lookup_port #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned TAG_WIDTH  = 44,
   parameter int unsigned SET_ASSOC  = 8,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic                            lookup_valid_i,
   output logic                            lookup_ready_o,
   input  logic [ADDR_WIDTH-1:0]           lookup_index_i,
   input  logic [TAG_WIDTH-1:0]            lookup_tag_i,
   output logic [SET_ASSOC-1:0]            req_o,
   input  logic                            gnt_i,
   output logic [ADDR_WIDTH-1:0]           addr_o,
   output logic                            we_o,
   output logic [TAG_WIDTH-1:0]            tag_o,
   input  logic [SET_ASSOC-1:0]            hit_way_i,
   input  logic [SET_ASSOC*LINE_WIDTH-1:0] way_data_i,
   output logic                            resp_valid_o,
   input  logic                            resp_ready_i,
   output logic                            resp_hit_o,
   output logic [SET_ASSOC-1:0]            resp_way_o,
   output logic [DATA_WIDTH-1:0]           resp_data_o,
`ifdef DCACHE_LOOKUP_PERF_EN
   output logic [31:0]                     perf_hit_cnt_o,
   output logic [31:0]                     perf_miss_cnt_o,
`endif
   output logic                            err_multi_hit_o
);

   localparam int unsigned OFF_LO = $clog2(DATA_WIDTH / 8);
   localparam int unsigned OFF_HI = $clog2(LINE_WIDTH / 8) - 1;
   localparam int unsigned WORDS  = LINE_WIDTH / DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_CMP, S_RESP} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   index_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic                    resp_hit_q;
   logic [SET_ASSOC-1:0]    resp_way_q;
   logic [DATA_WIDTH-1:0]   resp_data_q;

   logic                    multi_hit;
   logic                    cmp_hit;
   logic [LINE_WIDTH-1:0]   line;
   logic [DATA_WIDTH-1:0]   word;

   // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (lookup_valid_i) state_d = S_REQ;
            S_REQ:   if (gnt_i)          state_d = S_CMP;
            S_CMP:                       state_d = S_RESP;
            S_RESP:  if (resp_ready_i)   state_d = S_IDLE;
            default:                     state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      lookup_ready_o  = (state_q == S_IDLE);
      req_o           = (state_q == S_REQ) ? '1 : '0;
      addr_o          = (state_q == S_REQ) ? index_q : '0;
      tag_o           = (state_q == S_CMP) ? tag_q : '0;
      we_o            = 1'b0;
      resp_valid_o    = (state_q == S_RESP);
      resp_hit_o      = resp_valid_o & resp_hit_q;
      resp_way_o      = resp_valid_o ? resp_way_q  : '0;
      resp_data_o     = resp_valid_o ? resp_data_q : '0;
      err_multi_hit_o = (state_q == S_CMP) & multi_hit;
   end

   // Hit ways are masked and OR-reduced; a multi-hit is reported as a miss.
   always_comb begin
      line = '0;
      for (int w = 0; w < SET_ASSOC; w++) begin
         line = line | (way_data_i[w*LINE_WIDTH +: LINE_WIDTH] & {LINE_WIDTH{hit_way_i[w]}});
      end
   end

   assign multi_hit = !$onehot0(hit_way_i);
   assign cmp_hit   = (|hit_way_i) & !multi_hit;

   generate
      if (WORDS == 1) begin : g_word_full
         assign word = line;
      end else begin : g_word_sel
         logic [WORDS-1:0][DATA_WIDTH-1:0] line_words;
         assign line_words = line;
         assign word       = line_words[index_q[OFF_HI:OFF_LO]];
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         tag_q       <= '0;
         resp_hit_q  <= 1'b0;
         resp_way_q  <= '0;
         resp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && lookup_valid_i && !flush_i) begin
            index_q <= lookup_index_i;
            tag_q   <= lookup_tag_i;
         end
         if (state_q == S_CMP && !flush_i) begin
            resp_hit_q  <= cmp_hit;
            resp_way_q  <= cmp_hit ? hit_way_i : '0;
            resp_data_q <= cmp_hit ? word : '0;
         end
      end
   end

`ifdef DCACHE_LOOKUP_PERF_EN
   logic handshake;
   assign handshake = resp_valid_o & resp_ready_i & !flush_i;

   // Saturating counters, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_hit_cnt_o  <= '0;
         perf_miss_cnt_o <= '0;
      end else if (handshake) begin
         if (resp_hit_q  && perf_hit_cnt_o  != '1) perf_hit_cnt_o  <= perf_hit_cnt_o + 32'd1;
         if (!resp_hit_q && perf_miss_cnt_o != '1) perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule
